bit_count_sequencer: RTL

BIT_COUNT_SEQUENCER -- requirements
Module: bit_count_sequencer

---
 rtl/bit_count_pkg.sv | 17 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/bit_count_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bit_count_pkg.sv
// Shared FSM state encoding and default sizing for the bit-count sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bit_count_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_OUT_WIDTH = 4;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_TIMEOUT   = 2 * DEF_WIDTH + 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding operands waiting for the bit counter.
// Latency: head visible the cycle after the first push; pop takes effect on the edge.
// Backpressure: full blocks push; simultaneous push and pop keep occupancy unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign head_data = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage write and pointer/occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_count_sequencer.sv
// Feeds buffered operands to an external bit counter and captures its results.
// Latency: launch two cycles after push; result registered on the edge bc_done is seen.
// Backpressure: in_ready=!full; a held result stalls the FSM in LAUNCH with bc_start high.
module bit_count_sequencer
    import bit_count_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int TIMEOUT   = 2 * WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     bc_in,
    output logic                 bc_start,
    input  logic [OUT_WIDTH-1:0] bc_count,
    input  logic                 bc_done,
    output logic [WIDTH-1:0]     out_data,
    output logic [OUT_WIDTH-1:0] out_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [WIDTH-1:0]      w_fifo_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_timeout;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_out_data;
    logic [OUT_WIDTH-1:0]  r_out_count;
    logic                  r_err;

    // Ready is purely !full so upstream never sees a combinational path from the pop.
    assign in_ready = !w_fifo_full;
    assign w_push   = in_valid && !w_fifo_full;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .head_data (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // The head only moves on pop, which only happens when leaving LAUNCH.
    assign bc_in     = w_fifo_head;
    assign bc_start  = (r_state == ST_LAUNCH);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign err       = r_err;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, capture and pop decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Wait for the counter to drop a stale done before relaunching.
                if (!w_fifo_empty && !bc_done) begin
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (bc_done) begin
                    // With the result slot full and not draining, stay put; the counter holds.
                    if (!r_out_valid || out_ready) begin
                        w_capture   = 1'b1;
                        w_pop       = 1'b1;
                        w_state_nxt = ST_RELEASE;
                    end
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bc_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Count LAUNCH cycles spent waiting on the counter; cleared outside LAUNCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ST_LAUNCH) begin
            r_tmo_cnt <= '0;
        end else if (!bc_done) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Result register: a capture wins over a same-edge drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bc_in;
            r_out_count <= bc_count;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

endmodule
